// File: rtl/cla_sub_pipe.sv
// Pipelined N-bit subtractor (a - b - bin) on valid/ready streams.
// Each stage resolves one CHUNK-bit carry-lookahead slice; the last stage drives the output flops.
module cla_sub_pipe #(
    parameter int N     = 8,
    parameter int CHUNK = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf
);

    localparam int STAGES = N / CHUNK;

    // Everything a beat carries between stages: running carry, operand sign bits,
    // the a/~b operands and the difference bits resolved so far.
    typedef struct packed {
        logic         c;
        logic         am;
        logic         bm;
        logic [N-1:0] a;
        logic [N-1:0] nb;
        logic [N-1:0] d;
    } stage_t;

    // Returns {carry_out, sum}; every carry is formed from cin and group g/p terms.
    // NOTE: blocking assignments are correct here: this is pure combinational evaluation in order.
    function automatic logic [CHUNK:0] cla_slice(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             cin);
        logic [CHUNK-1:0] g, p;
        logic [CHUNK:0]   c;
        logic             gg, pp;
        g    = x & y;
        p    = x ^ y;
        c    = '0;
        c[0] = cin;
        gg   = 1'b0;
        pp   = 1'b1;
        for (int i = 0; i < CHUNK; i++) begin
            gg       = g[i] | (p[i] & gg);
            pp       = pp & p[i];
            c[i + 1] = gg | (pp & cin);
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] v_up;
    logic [STAGES-1:0] adv;

    assign v_up      = STAGES'({v_q, in_valid});
    assign in_ready  = adv[0];
    assign out_valid = v_q[STAGES-1];

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= '0;
        end else begin
            v_q <= (adv & v_up) | (~adv & v_q);
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : stg
        stage_t         up;
        stage_t         nxt;
        logic [CHUNK:0] res;

        // A stage moves when it or any stage downstream of it is empty, or the consumer takes a beat.
        assign adv[k] = out_ready | ~(&v_q[STAGES-1:k]);

        if (k == 0) begin : g_src
            assign up = '{c: ~bin, am: a[N-1], bm: b[N-1], a: a, nb: ~b, d: '0};
        end else begin : g_src
            assign up = stg[k-1].g_reg.q;
        end

        assign res = cla_slice(up.a[k*CHUNK +: CHUNK], up.nb[k*CHUNK +: CHUNK], up.c);

        // NOTE: nxt takes a full default first so no path leaves it unassigned (no latch).
        always_comb begin
            nxt                    = up;
            nxt.c                  = res[CHUNK];
            nxt.d[k*CHUNK +: CHUNK] = res[CHUNK-1:0];
        end

        if (k < STAGES - 1) begin : g_reg
            stage_t q;
            // NOTE: payload flops carry no reset; v_q alone says whether they hold a live beat.
            always_ff @(posedge clk) begin
                if (adv[k]) begin
                    q <= nxt;
                end
            end
        end else begin : g_out
            logic unused_ops;
            assign unused_ops = ^{nxt.a, nxt.nb};

            // Output flops only load real beats, so they stay clean across bubbles and reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    diff <= '0;
                    bout <= 1'b0;
                    ovf  <= 1'b0;
                end else if (adv[k] && v_up[k]) begin
                    diff <= nxt.d;
                    bout <= ~nxt.c;
                    ovf  <= (nxt.am != nxt.bm) && (nxt.d[N-1] != nxt.am);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Directed and randomized checks of cla_sub_pipe at (8,4), (16,4) and (8,8).
// Expected values are hand constants or an integer-arithmetic reference model.
module tb_cla_sub_pipe;

    localparam int NB = 10000;

    logic clk;
    logic rst_n;

    logic        iv8, ir8, ov8, or8, bin8, bout8, ovf8;
    logic [7:0]  a8, b8, diff8;
    logic        iv16, ir16, ov16, or16, bin16, bout16, ovf16;
    logic [15:0] a16, b16, diff16;
    logic        iv88, ir88, ov88, or88, bin88, bout88, ovf88;
    logic [7:0]  a88, b88, diff88;

    int checks   = 0;
    int failures = 0;

    cla_sub_pipe #(.N(8), .CHUNK(4)) u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .bin(bin8),
        .out_valid(ov8), .out_ready(or8), .diff(diff8), .bout(bout8), .ovf(ovf8)
    );

    cla_sub_pipe #(.N(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .bin(bin16),
        .out_valid(ov16), .out_ready(or16), .diff(diff16), .bout(bout16), .ovf(ovf16)
    );

    cla_sub_pipe #(.N(8), .CHUNK(8)) u88 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv88), .in_ready(ir88), .a(a88), .b(b88), .bin(bin88),
        .out_valid(ov88), .out_ready(or88), .diff(diff88), .bout(bout88), .ovf(ovf88)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference: wide integer arithmetic, independent of the carry formulation.
    function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y, input logic bi);
        int          sr;
        logic [15:0] d;
        logic        bo, ov;
        d  = x - y - {15'd0, bi};
        bo = int'(x) < (int'(y) + int'(bi));
        sr = int'($signed(x)) - int'($signed(y)) - int'(bi);
        ov = (sr > 32767) || (sr < -32768);
        return {d, bo, ov};
    endfunction

    function automatic logic [9:0] model8(input logic [7:0] x, input logic [7:0] y, input logic bi);
        int         sr;
        logic [7:0] d;
        logic       bo, ov;
        d  = x - y - {7'd0, bi};
        bo = int'(x) < (int'(y) + int'(bi));
        sr = int'($signed(x)) - int'($signed(y)) - int'(bi);
        ov = (sr > 127) || (sr < -128);
        return {d, bo, ov};
    endfunction

    // One beat through the 2-stage instance with out_ready high; checks latency and result.
    task automatic send8(input string tag, input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                         input logic [7:0] ed, input logic eb, input logic eo);
        a8   = ta;
        b8   = tb;
        bin8 = tbin;
        iv8  = 1'b1;
        or8  = 1'b1;
        #1;
        check({tag, "_rdy"}, 32'(ir8), 32'd1);
        tick();
        iv8 = 1'b0;
        check({tag, "_early"}, 32'(ov8), 32'd0);
        tick();
        check({tag, "_valid"}, 32'(ov8), 32'd1);
        check({tag, "_diff"}, 32'(diff8), 32'(ed));
        check({tag, "_bout"}, 32'(bout8), 32'(eb));
        check({tag, "_ovf"}, 32'(ovf8), 32'(eo));
    endtask

    logic [17:0] q16[$];
    logic [9:0]  q88[$];
    logic [9:0]  held;
    logic [17:0] e16;
    logic [9:0]  e88;
    int          sent, recv, tx16, rx16, tx88, rx88;
    logic        stalled_prev;

    initial begin
        rst_n = 1'b0;
        {iv8, or8, bin8, a8, b8}       = '0;
        {iv16, or16, bin16, a16, b16}  = '0;
        {iv88, or88, bin88, a88, b88}  = '0;
        #3;
        check("rst_valid", 32'(ov8), 32'd0);
        check("rst_diff", 32'(diff8), 32'd0);
        check("rst_bout", 32'(bout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_valid_88", 32'(ov88), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 32'(ir8), 32'd1);

        send8("basic", 8'h50, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0);
        send8("underflow", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
        send8("xchunk", 8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b0);
        send8("ovf_neg", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
        send8("ovf_pos", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);
        send8("bin_wrap", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        tick();

        // Back-pressure: six beats, consumer stalls during cycles 2..5.
        sent         = 0;
        recv         = 0;
        stalled_prev = 1'b0;
        held         = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            iv8  = (sent < 6);
            a8   = 8'(32'h20 * sent + 7);
            b8   = 8'(sent);
            bin8 = 1'b0;
            or8  = !(cyc >= 2 && cyc <= 5);
            #1;
            check("bp_ready", 32'(ir8), 32'(or8 || (sent - recv) < 2));
            if (ov8) begin
                if (stalled_prev) check("bp_hold", 32'({diff8, bout8, ovf8}), 32'(held));
                if (or8) begin
                    check("bp_extra", 32'(recv < 6), 32'd1);
                    check("bp_order", 32'(diff8), 32'(8'(32'h20 * recv + 7 - recv)));
                    recv++;
                end
                held = {diff8, bout8, ovf8};
            end
            stalled_prev = ov8 && !or8;
            if (iv8 && ir8) sent++;
            tick();
        end
        check("bp_sent", 32'(sent), 32'd6);
        check("bp_recv", 32'(recv), 32'd6);

        // Reset with two beats in flight.
        iv8 = 1'b1; a8 = 8'h00; b8 = 8'h01; bin8 = 1'b0; or8 = 1'b0;
        tick();
        a8 = 8'h30; b8 = 8'h10;
        tick();
        iv8 = 1'b0;
        check("mr_pre_valid", 32'(ov8), 32'd1);
        check("mr_pre_diff", 32'(diff8), 32'hFF);
        #1;
        rst_n = 1'b0;
        #1;
        check("mr_valid", 32'(ov8), 32'd0);
        check("mr_diff", 32'(diff8), 32'd0);
        check("mr_bout", 32'(bout8), 32'd0);
        check("mr_ovf", 32'(ovf8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        or8   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("mr_no_stale", 32'(ov8), 32'd0);
        end
        send8("mr_new", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);

        // Single-stage instance: latency of one edge.
        a88 = 8'h50; b88 = 8'h20; bin88 = 1'b0; iv88 = 1'b1; or88 = 1'b1;
        tick();
        iv88 = 1'b0;
        check("s1_valid", 32'(ov88), 32'd1);
        check("s1_diff", 32'(diff88), 32'h30);
        tick();
        check("s1_drain", 32'(ov88), 32'd0);

        // Randomized streams on the (16,4) and (8,8) instances against the model.
        tx16 = 0; rx16 = 0; tx88 = 0; rx88 = 0;
        for (int cyc = 0; cyc < 40000 && (rx16 < NB || rx88 < NB); cyc++) begin
            iv16  = (tx16 < NB) && ($urandom_range(3) != 0);
            a16   = 16'($urandom);
            b16   = 16'($urandom);
            bin16 = 1'($urandom);
            or16  = ($urandom_range(3) != 0);
            iv88  = (tx88 < NB) && ($urandom_range(3) != 0);
            a88   = 8'($urandom);
            b88   = 8'($urandom);
            bin88 = 1'($urandom);
            or88  = ($urandom_range(3) != 0);
            #1;
            if (iv16 && ir16) begin
                q16.push_back(model16(a16, b16, bin16));
                tx16++;
            end
            if (ov16 && or16) begin
                check("rnd16_pending", 32'(q16.size() != 0), 32'd1);
                if (q16.size() != 0) begin
                    e16 = q16.pop_front();
                    check("rnd16_result", 32'({diff16, bout16, ovf16}), 32'(e16));
                end
                rx16++;
            end
            if (iv88 && ir88) begin
                q88.push_back(model8(a88, b88, bin88));
                tx88++;
            end
            if (ov88 && or88) begin
                check("rnd88_pending", 32'(q88.size() != 0), 32'd1);
                if (q88.size() != 0) begin
                    e88 = q88.pop_front();
                    check("rnd88_result", 32'({diff88, bout88, ovf88}), 32'(e88));
                end
                rx88++;
            end
            tick();
        end
        iv16 = 1'b0;
        iv88 = 1'b0;
        check("rnd16_count", 32'(rx16), 32'(NB));
        check("rnd16_left", 32'(q16.size()), 32'd0);
        check("rnd88_count", 32'(rx88), 32'(NB));
        check("rnd88_left", 32'(q88.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
